w_stage_grf: RTL and testbench
==============================

// Module: w_stage_grf
// PURPOSE
//   Writeback stage plus general register file of the 5-stage MIPS pipeline (mult/div capable).
//   Consumes the MEM/WB pipeline register outputs and selects the writeback value among ALU result,
//   load data, link address and HI/LO (md) result, then commits it to the 32x32 GRF.
//   Provides the D-stage read ports with internal write-through, the W-stage forwarding source,
//   and a commit trace/retire counter for the auto-judge.
// PARAMETERS
//   LINK_OFFSET  8   added to W-stage PC to form the jal/jalr link value (delay slot)
//   RETIRE_W     32  width of the retired-instruction counter
// PORTS
//   clk         in   1         system clock; all state updates on posedge
//   reset       in   1         synchronous, active-high reset
//   w_alu       in   32        ALU result from MEM/WB register
//   w_dm        in   32        load data (already extended) from MEM/WB register
//   w_pc        in   32        PC of the W-stage instruction
//   w_md        in   32        HI/LO read value (mfhi/mflo) from MEM/WB register
//   w_instr     in   32        W-stage instruction word; 0 = bubble (nop)
//   wb_sel      in   2         writeback source: 0 ALU, 1 DM, 2 PC+LINK_OFFSET, 3 MD
//   wb_we       in   1         GRF write request
//   wb_a3       in   5         GRF destination register
//   rs_addr     in   5         D-stage read address 1
//   rt_addr     in   5         D-stage read address 2
//   rs_data     out  32        read data 1 (combinational, with write-through)
//   rt_data     out  32        read data 2 (combinational, with write-through)
//   fwd_wd      out  32        W-stage writeback value (forwarding source for E/M)
//   fwd_a3      out  5         effective destination: wb_a3 if commit, else 0
//   dbg_commit  out  1         1 in any cycle a nonzero-register write commits at next edge
//   dbg_pc      out  32        = w_pc (trace)
//   retire_cnt  out  RETIRE_W  registered count of retired non-bubble instructions
// BEHAVIOUR
//   - wd = mux(wb_sel): ALU / DM / w_pc+LINK_OFFSET (32-bit wrap) / MD; fwd_wd = wd always.
//   - commit = wb_we & (wb_a3 != 0) & ~reset. fwd_a3 = commit ? wb_a3 : 0; dbg_commit = commit.
//   - Posedge: reset -> all 32 regs <= 0, retire_cnt <= 0 (reset wins over any pending write).
//     else if commit -> grf[wb_a3] <= wd, visible from register array the following cycle.
//   - $0 hardwired: never written, reads always return 0 (even if wb_a3=0 & wb_we=1).
//   - Read ports: addr==0 -> 0; else if commit & addr==wb_a3 -> wd (same-cycle write-through,
//     zero latency); else grf[addr]. rs/rt independent; both may hit the bypass simultaneously.
//   - Bypass gated by ~reset: during a reset cycle reads return stored array contents.
//   - retire_cnt: +1 at posedge when ~reset & w_instr != 0; wraps 2^RETIRE_W-1 -> 0.
//     Bubbles (w_instr == 0) never count, even if wb_we is erroneously high.
//   - No stall input: the MEM/WB register is responsible for freezing/bubbling; this block is
//     purely reactive to its current inputs, so a held instruction rewrites the same value.
//   - Reset mid-operation: in-flight W instruction is dropped (no write, no count); the first
//     post-reset cycle behaves as a fresh pipeline (all reads 0 until written).
//   - No X propagation: wb_sel covers all 4 codes; reads of unwritten regs return 0 after reset.
// TESTING
//   1 reset 1 cycle, then read all 32 regs -> every rs_data/rt_data = 0, retire_cnt = 0.
//   2 wb_sel=0,w_alu=0x1234_5678,wb_we=1,wb_a3=5,rs_addr=5 same cycle -> rs_data=0x1234_5678
//     (bypass), next cycle with wb_we=0 still 0x1234_5678 (array).
//   3 wb_sel=2,w_pc=0x0000_3004,wb_a3=31 -> grf[31]=0x0000_300C; wb_sel=3,w_md=0xDEAD_BEEF,
//     wb_a3=2 -> grf[2]=0xDEAD_BEEF; wb_sel=1,w_dm=0xFFFF_FF80 -> loaded value stored unchanged.
//   4 wb_we=1,wb_a3=0,w_alu=0xFFFF_FFFF,rs_addr=0 -> rs_data=0, fwd_a3=0, dbg_commit=0.
//   5 reset asserted together with wb_we=1,wb_a3=7 after grf[7]=0x11 -> rt_addr=7 reads 0x11
//     during reset cycle, 0 afterward; retire_cnt=0.
//   6 10 instrs interleaved with 3 bubbles (w_instr=0) -> retire_cnt=10; preload counter via
//     RETIRE_W=4 build, 16 retires -> wraps to 0.

Source files
------------

// File: rtl/w_stage_grf_if.sv
// w_stage_grf_if: MEM/WB writeback inputs, D-stage GRF read ports, W-stage forwarding and commit trace.
interface w_stage_grf_if #(parameter int RETIRE_W = 32);
    logic [31:0] w_alu;
    logic [31:0] w_dm;
    logic [31:0] w_pc;
    logic [31:0] w_md;
    logic [31:0] w_instr;
    logic [1:0] wb_sel;
    logic wb_we;
    logic [4:0] wb_a3;
    logic [4:0] rs_addr;
    logic [4:0] rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] fwd_wd;
    logic [4:0] fwd_a3;
    logic dbg_commit;
    logic [31:0] dbg_pc;
    logic [RETIRE_W-1:0] retire_cnt;
    modport master (
        output w_alu, w_dm, w_pc, w_md, w_instr, wb_sel, wb_we, wb_a3, rs_addr, rt_addr,
        input rs_data, rt_data, fwd_wd, fwd_a3, dbg_commit, dbg_pc, retire_cnt
    );
    modport slave (
        input w_alu, w_dm, w_pc, w_md, w_instr, wb_sel, wb_we, wb_a3, rs_addr, rt_addr,
        output rs_data, rt_data, fwd_wd, fwd_a3, dbg_commit, dbg_pc, retire_cnt
    );
endinterface

// File: rtl/w_stage_grf.sv
// w_stage_grf: MIPS writeback select and 32x32 GRF with write-through read ports and retire counter.
module w_stage_grf #(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter int RETIRE_W = 32
) (
    input logic clk,
    input logic reset,
    w_stage_grf_if.slave bus
);
    logic [31:0] grf_q [32];
    logic [RETIRE_W-1:0] retire_q;
    logic [RETIRE_W-1:0] retire_d;
    logic [31:0] wd;
    logic commit;
    // bypass is gated by commit, which already excludes $0 and reset cycles
    always_comb begin
        wd = bus.wb_sel == 2'd0 ? bus.w_alu :
             bus.wb_sel == 2'd1 ? bus.w_dm :
             bus.wb_sel == 2'd2 ? bus.w_pc + LINK_OFFSET : bus.w_md;
        commit = bus.wb_we && bus.wb_a3 != 5'd0 && !reset;
        retire_d = bus.w_instr != 32'd0 ? retire_q + RETIRE_W'(1) : retire_q;
        bus.rs_data = bus.rs_addr == 5'd0 ? 32'd0 :
                      (commit && bus.rs_addr == bus.wb_a3) ? wd : grf_q[bus.rs_addr];
        bus.rt_data = bus.rt_addr == 5'd0 ? 32'd0 :
                      (commit && bus.rt_addr == bus.wb_a3) ? wd : grf_q[bus.rt_addr];
        bus.fwd_wd = wd;
        bus.fwd_a3 = commit ? bus.wb_a3 : 5'd0;
        bus.dbg_commit = commit;
        bus.dbg_pc = bus.w_pc;
        bus.retire_cnt = retire_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) grf_q[i] <= 32'd0;
            retire_q <= '0;
        end else begin
            if (commit) grf_q[bus.wb_a3] <= wd;
            retire_q <= retire_d;
        end
    end
endmodule

// File: tb/tb_w_stage_grf.sv
// tb_w_stage_grf: directed tests of writeback select, GRF write-through, $0, reset and retire counting.
module tb_w_stage_grf;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    w_stage_grf_if #(.RETIRE_W(32)) bus ();
    w_stage_grf_if #(.RETIRE_W(4)) bus4 ();
    w_stage_grf #(.LINK_OFFSET(32'd8), .RETIRE_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    w_stage_grf #(.LINK_OFFSET(32'd8), .RETIRE_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    assign bus4.w_alu = bus.w_alu;
    assign bus4.w_dm = bus.w_dm;
    assign bus4.w_pc = bus.w_pc;
    assign bus4.w_md = bus.w_md;
    assign bus4.w_instr = bus.w_instr;
    assign bus4.wb_sel = bus.wb_sel;
    assign bus4.wb_we = bus.wb_we;
    assign bus4.wb_a3 = bus.wb_a3;
    assign bus4.rs_addr = bus.rs_addr;
    assign bus4.rt_addr = bus.rt_addr;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.w_alu = 32'd0; bus.w_dm = 32'd0; bus.w_pc = 32'd0; bus.w_md = 32'd0;
        bus.w_instr = 32'd0; bus.wb_sel = 2'd0; bus.wb_we = 1'b0; bus.wb_a3 = 5'd0;
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rs_addr = 5'(i);
            bus.rt_addr = 5'(31 - i);
            #1;
            checks++; if (bus.rs_data !== 32'd0) begin errors++; $display("FAIL reset_rs[%0d] got %h exp 0", i, bus.rs_data); end
            checks++; if (bus.rt_data !== 32'd0) begin errors++; $display("FAIL reset_rt[%0d] got %h exp 0", 31 - i, bus.rt_data); end
        end
        checks++; if (bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.retire_cnt); end
    endtask

    task automatic test_bypass;
        idle();
        bus.w_instr = 32'h2405_0001; bus.wb_sel = 2'd0; bus.w_alu = 32'h1234_5678;
        bus.wb_we = 1'b1; bus.wb_a3 = 5'd5; bus.rs_addr = 5'd5; bus.rt_addr = 5'd5; bus.w_pc = 32'h0000_3000;
        #1;
        checks++; if (bus.rs_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rs got %h exp 12345678", bus.rs_data); end
        checks++; if (bus.rt_data !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rt got %h exp 12345678", bus.rt_data); end
        checks++; if (bus.fwd_a3 !== 5'd5) begin errors++; $display("FAIL bypass_fwd_a3 got %0d exp 5", bus.fwd_a3); end
        checks++; if (bus.dbg_commit !== 1'b1) begin errors++; $display("FAIL bypass_commit got %b exp 1", bus.dbg_commit); end
        checks++; if (bus.dbg_pc !== 32'h0000_3000) begin errors++; $display("FAIL dbg_pc got %h exp 00003000", bus.dbg_pc); end
        tick();
        bus.wb_we = 1'b0; bus.w_instr = 32'd0; bus.w_alu = 32'h0;
        #1;
        checks++; if (bus.rs_data !== 32'h1234_5678) begin errors++; $display("FAIL array_rs got %h exp 12345678", bus.rs_data); end
        checks++; if (bus.fwd_a3 !== 5'd0) begin errors++; $display("FAIL nowrite_fwd_a3 got %0d exp 0", bus.fwd_a3); end
    endtask

    task automatic test_sources;
        idle();
        bus.w_instr = 32'h0c00_0c00; bus.wb_we = 1'b1;
        bus.wb_sel = 2'd2; bus.w_pc = 32'h0000_3004; bus.wb_a3 = 5'd31;
        #1;
        checks++; if (bus.fwd_wd !== 32'h0000_300C) begin errors++; $display("FAIL link_wd got %h exp 0000300c", bus.fwd_wd); end
        tick();
        bus.wb_sel = 2'd3; bus.w_md = 32'hDEAD_BEEF; bus.wb_a3 = 5'd2;
        tick();
        bus.wb_sel = 2'd1; bus.w_dm = 32'hFFFF_FF80; bus.wb_a3 = 5'd3;
        tick();
        idle();
        bus.wb_sel = 2'd2; bus.w_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (bus.fwd_wd !== 32'h0000_0004) begin errors++; $display("FAIL link_wrap got %h exp 00000004", bus.fwd_wd); end
        bus.rs_addr = 5'd31; bus.rt_addr = 5'd2;
        #1;
        checks++; if (bus.rs_data !== 32'h0000_300C) begin errors++; $display("FAIL grf31 got %h exp 0000300c", bus.rs_data); end
        checks++; if (bus.rt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL grf2 got %h exp deadbeef", bus.rt_data); end
        bus.rs_addr = 5'd3;
        #1;
        checks++; if (bus.rs_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL grf3 got %h exp ffffff80", bus.rs_data); end
    endtask

    task automatic test_zero;
        idle();
        bus.w_instr = 32'h2400_ffff; bus.wb_we = 1'b1; bus.wb_a3 = 5'd0; bus.w_alu = 32'hFFFF_FFFF;
        #1;
        checks++; if (bus.rs_data !== 32'd0) begin errors++; $display("FAIL zero_rs got %h exp 0", bus.rs_data); end
        checks++; if (bus.fwd_a3 !== 5'd0) begin errors++; $display("FAIL zero_fwd_a3 got %0d exp 0", bus.fwd_a3); end
        checks++; if (bus.dbg_commit !== 1'b0) begin errors++; $display("FAIL zero_commit got %b exp 0", bus.dbg_commit); end
        checks++; if (bus.fwd_wd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_fwd_wd got %h exp ffffffff", bus.fwd_wd); end
        tick();
        idle();
        #1;
        checks++; if (bus.rt_data !== 32'd0) begin errors++; $display("FAIL zero_after got %h exp 0", bus.rt_data); end
    endtask

    task automatic test_back_to_back;
        idle();
        bus.w_instr = 32'h1; bus.wb_we = 1'b1; bus.wb_a3 = 5'd4; bus.w_alu = 32'hAAAA_0001;
        bus.rs_addr = 5'd4; bus.rt_addr = 5'd4;
        tick();
        bus.w_alu = 32'hBBBB_0002;
        #1;
        checks++; if (bus.rs_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_rs got %h exp bbbb0002", bus.rs_data); end
        checks++; if (bus.rt_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_rt got %h exp bbbb0002", bus.rt_data); end
        tick();
        tick();
        bus.wb_we = 1'b0; bus.w_instr = 32'd0;
        #1;
        checks++; if (bus.rs_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_held got %h exp bbbb0002", bus.rs_data); end
        bus.rt_addr = 5'd6; bus.wb_we = 1'b1; bus.wb_a3 = 5'd5;
        #1;
        checks++; if (bus.rt_data !== 32'd0) begin errors++; $display("FAIL b2b_other got %h exp 0", bus.rt_data); end
        bus.wb_we = 1'b0;
    endtask

    task automatic test_reset_mid;
        idle();
        bus.w_instr = 32'h2407_0011; bus.wb_we = 1'b1; bus.wb_a3 = 5'd7; bus.w_alu = 32'h11;
        tick();
        reset = 1'b1;
        bus.w_alu = 32'h99; bus.rt_addr = 5'd7; bus.rs_addr = 5'd4;
        #1;
        checks++; if (bus.rt_data !== 32'h11) begin errors++; $display("FAIL rstmid_rt got %h exp 00000011", bus.rt_data); end
        checks++; if (bus.rs_data !== 32'hBBBB_0002) begin errors++; $display("FAIL rstmid_rs got %h exp bbbb0002", bus.rs_data); end
        checks++; if (bus.dbg_commit !== 1'b0) begin errors++; $display("FAIL rstmid_commit got %b exp 0", bus.dbg_commit); end
        checks++; if (bus.fwd_a3 !== 5'd0) begin errors++; $display("FAIL rstmid_fwd_a3 got %0d exp 0", bus.fwd_a3); end
        tick();
        reset = 1'b0;
        bus.wb_we = 1'b0; bus.w_instr = 32'd0;
        #1;
        checks++; if (bus.rt_data !== 32'd0) begin errors++; $display("FAIL rstpost_rt got %h exp 0", bus.rt_data); end
        checks++; if (bus.rs_data !== 32'd0) begin errors++; $display("FAIL rstpost_rs got %h exp 0", bus.rs_data); end
        checks++; if (bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL rstpost_cnt got %0d exp 0", bus.retire_cnt); end
    endtask

    task automatic test_retire;
        logic [12:0] pattern;
        pattern = 13'b1101101101111;
        idle();
        for (int i = 0; i < 13; i++) begin
            bus.w_instr = pattern[i] ? 32'h0000_0020 + 32'(i) : 32'd0;
            bus.wb_we = 1'b1; bus.wb_a3 = 5'd9; bus.w_alu = 32'(i);
            tick();
        end
        idle();
        #1;
        checks++; if (bus.retire_cnt !== 32'd10) begin errors++; $display("FAIL retire_cnt got %0d exp 10", bus.retire_cnt); end
        checks++; if (bus4.retire_cnt !== 4'd10) begin errors++; $display("FAIL retire_cnt4 got %0d exp 10", bus4.retire_cnt); end
    endtask

    task automatic test_wrap;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.w_instr = 32'h0000_0001;
        for (int i = 0; i < 15; i++) tick();
        #1;
        checks++; if (bus4.retire_cnt !== 4'd15) begin errors++; $display("FAIL wrap_max got %0d exp 15", bus4.retire_cnt); end
        tick();
        idle();
        #1;
        checks++; if (bus4.retire_cnt !== 4'd0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", bus4.retire_cnt); end
        checks++; if (bus.retire_cnt !== 32'd16) begin errors++; $display("FAIL wrap_cnt32 got %0d exp 16", bus.retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_sources();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_retire();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
